// File: rtl/serial_slave_rx_if.sv
// serial_slave_rx_if: master/slave signal bundle for the serial receive port
interface serial_slave_rx_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8,
    parameter int BLEN_W = 12
);
    logic              m_valid;
    logic              read_enable;
    logic              write_enable;
    logic              rx_address;
    logic              rx_data;
    logic              m_ready;
    logic              burst_en;
    logic [BLEN_W-1:0] burst_len;
    logic              s_ready;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              rd_strobe;
    logic              wr_strobe;
    logic [BLEN_W-1:0] beat_count;
    logic              last_beat;
    logic              busy;
    logic              err;

    modport master (
        output m_valid, read_enable, write_enable, rx_address, rx_data, m_ready, burst_en, burst_len,
        input  s_ready, addr, data, rd_strobe, wr_strobe, beat_count, last_beat, busy, err
    );

    modport slave (
        input  m_valid, read_enable, write_enable, rx_address, rx_data, m_ready, burst_en, burst_len,
        output s_ready, addr, data, rd_strobe, wr_strobe, beat_count, last_beat, busy, err
    );
endinterface

// File: rtl/serial_slave_rx.sv
// serial_slave_rx: deserialises LSB-first address/data and issues single or burst read/write strobes
module serial_slave_rx #(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 8,
    parameter int BLEN_W     = 12,
    parameter int GAP_CYCLES = 4
) (
    input logic               clk,
    input logic               reset,
    serial_slave_rx_if.slave  bus
);
    localparam int CW = (ADDR_W > 1) ? $clog2(ADDR_W) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    if (DATA_W < 1 || DATA_W > ADDR_W) begin : g_bad_data_w
        $error("DATA_W must lie in 1..ADDR_W");
    end

    typedef enum logic [2:0] {IDLE, ADDR_RX, DATA_RX, STROBE, WAIT_HS, WAIT_RD, GAP} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [BLEN_W-1:0] beat_q, beat_d;
    logic [BLEN_W-1:0] beats_q, beats_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [GW-1:0]     gap_q, gap_d;
    logic              wr_q, wr_d;
    logic              err_q, err_d;
    logic              s_ready;
    logic              hs;
    logic              is_last;
    logic [ADDR_W-1:0] amask;
    logic [DATA_W-1:0] dmask;

    assign s_ready = (state_q == IDLE) || (state_q == WAIT_HS);
    assign hs      = bus.m_valid && s_ready;
    assign is_last = beat_q == beats_q - BLEN_W'(1);
    assign amask   = ADDR_W'(1) << cnt_q;
    assign dmask   = DATA_W'(1) << cnt_q;

    // Next-state and datapath: bit i of a phase lands at position cnt_q on cycle i after its handshake
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        beat_d  = beat_q;
        beats_d = beats_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        wr_d    = wr_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (hs && (bus.read_enable ^ bus.write_enable)) begin
                    wr_d      = bus.write_enable;
                    beats_d   = bus.burst_en ? ((bus.burst_len == '0) ? BLEN_W'(1) : bus.burst_len) : BLEN_W'(1);
                    addr_d[0] = bus.rx_address;
                    data_d[0] = bus.rx_data;
                    beat_d    = '0;
                    cnt_d     = CW'(1);
                    state_d   = (ADDR_W == 1) ? STROBE : ADDR_RX;
                end else if (hs) begin
                    err_d = 1'b1;
                end
            end
            ADDR_RX: begin
                addr_d = bus.rx_address ? (addr_q | amask) : (addr_q & ~amask);
                if (wr_q && 32'(cnt_q) < DATA_W) begin
                    data_d = bus.rx_data ? (data_q | dmask) : (data_q & ~dmask);
                end
                if (32'(cnt_q) == ADDR_W - 1) begin
                    state_d = STROBE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DATA_RX: begin
                data_d = bus.rx_data ? (data_q | dmask) : (data_q & ~dmask);
                if (32'(cnt_q) == DATA_W - 1) begin
                    state_d = STROBE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            STROBE: begin
                state_d = is_last ? IDLE : (wr_q ? WAIT_HS : WAIT_RD);
            end
            WAIT_HS: begin
                if (hs) begin
                    addr_d    = addr_q + ADDR_W'(1);
                    beat_d    = beat_q + BLEN_W'(1);
                    data_d[0] = bus.rx_data;
                    cnt_d     = CW'(1);
                    state_d   = (DATA_W == 1) ? STROBE : DATA_RX;
                end
            end
            WAIT_RD: begin
                if (bus.m_ready) begin
                    addr_d  = addr_q + ADDR_W'(1);
                    beat_d  = beat_q + BLEN_W'(1);
                    gap_d   = '0;
                    state_d = (GAP_CYCLES == 0) ? STROBE : GAP;
                end
            end
            GAP: begin
                if (32'(gap_q) == GAP_CYCLES - 1) begin
                    state_d = STROBE;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset discards any transfer in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            beat_q  <= '0;
            beats_q <= '0;
            cnt_q   <= '0;
            gap_q   <= '0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            beat_q  <= beat_d;
            beats_q <= beats_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
        end
    end

    assign bus.s_ready    = s_ready;
    assign bus.addr       = addr_q;
    assign bus.data       = data_q;
    assign bus.beat_count = beat_q;
    assign bus.rd_strobe  = (state_q == STROBE) && !wr_q;
    assign bus.wr_strobe  = (state_q == STROBE) && wr_q;
    assign bus.last_beat  = (state_q == STROBE) && is_last;
    assign bus.busy       = state_q != IDLE;
    assign bus.err        = err_q;
endmodule

// File: tb/tb_serial_slave_rx.sv
// tb_serial_slave_rx: randomized scoreboard bench; DUT0 uses a 4-cycle read gap, DUT1 none
module tb_serial_slave_rx;
    localparam int AW = 12;
    localparam int DW = 8;
    localparam int BW = 12;

    typedef struct {
        int          cyc;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int          beat;
        bit          last;
        bit          wr;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    exp_t q[2][$];
    int   eq[2][$];

    logic          sel, mv, re, we, ra, rdat, mr, be;
    logic [BW-1:0] bl;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_slave_rx_if #(.ADDR_W(AW), .DATA_W(DW), .BLEN_W(BW)) b0 ();
    serial_slave_rx_if #(.ADDR_W(AW), .DATA_W(DW), .BLEN_W(BW)) b1 ();

    assign b0.m_valid = mv && !sel;
    assign b1.m_valid = mv && sel;
    assign b0.m_ready = mr && !sel;
    assign b1.m_ready = mr && sel;
    assign b0.read_enable = re;
    assign b1.read_enable = re;
    assign b0.write_enable = we;
    assign b1.write_enable = we;
    assign b0.rx_address = ra;
    assign b1.rx_address = ra;
    assign b0.rx_data = rdat;
    assign b1.rx_data = rdat;
    assign b0.burst_en = be;
    assign b1.burst_en = be;
    assign b0.burst_len = bl;
    assign b1.burst_len = bl;

    serial_slave_rx #(.ADDR_W(AW), .DATA_W(DW), .BLEN_W(BW), .GAP_CYCLES(4)) dut0 (.clk(clk), .reset(reset), .bus(b0));
    serial_slave_rx #(.ADDR_W(AW), .DATA_W(DW), .BLEN_W(BW), .GAP_CYCLES(0)) dut1 (.clk(clk), .reset(reset), .bus(b1));

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic push(input bit s, input int c, input logic [AW-1:0] a, input logic [DW-1:0] d, input int k, input bit l, input bit w);
        exp_t e;
        e.cyc = c; e.a = a; e.d = d; e.beat = k; e.last = l; e.wr = w;
        q[s].push_back(e);
    endtask

    // Scoreboard side: pop the expected beat whenever a DUT strobes or flags an error
    task automatic mon(input bit s, input logic rs, input logic ws, input logic lb, input logic er,
                       input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] bc);
        exp_t e;
        int ec;
        while (q[s].size() > 0 && q[s][0].cyc < cyc) begin
            e = q[s].pop_front();
            n_chk++; n_fail++;
            $display("FAIL missed_strobe dut%0d: no strobe seen, required at cycle %0d addr %0h", s, e.cyc, e.a);
        end
        while (eq[s].size() > 0 && eq[s][0] < cyc) begin
            ec = eq[s].pop_front();
            n_chk++; n_fail++;
            $display("FAIL missed_err dut%0d: err low, required high at cycle %0d", s, ec);
        end
        if (rs === 1'b1 || ws === 1'b1) begin
            if (q[s].size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL unexpected_strobe dut%0d: rd=%b wr=%b at cycle %0d, required none", s, rs, ws, cyc);
            end else begin
                e = q[s].pop_front();
                cmp("strobe_cycle", 32'(cyc), 32'(e.cyc));
                cmp("wr_strobe", 32'(ws), 32'(e.wr));
                cmp("rd_strobe", 32'(rs), 32'(!e.wr));
                cmp("addr", 32'(a), 32'(e.a));
                if (e.wr) cmp("data", 32'(d), 32'(e.d));
                cmp("beat_count", 32'(bc), 32'(e.beat));
                cmp("last_beat", 32'(lb), 32'(e.last));
            end
        end else if (lb === 1'b1) begin
            n_chk++; n_fail++;
            $display("FAIL last_beat_alone dut%0d: last_beat=1 without strobe at cycle %0d, required 0", s, cyc);
        end
        if (er === 1'b1) begin
            if (eq[s].size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL unexpected_err dut%0d: err=1 at cycle %0d, required 0", s, cyc);
            end else begin
                ec = eq[s].pop_front();
                cmp("err_cycle", 32'(cyc), 32'(ec));
            end
        end
    endtask

    // Monitor process, decoupled from stimulus
    always @(negedge clk) begin
        mon(1'b0, b0.rd_strobe, b0.wr_strobe, b0.last_beat, b0.err, b0.addr, b0.data, b0.beat_count);
        mon(1'b1, b1.rd_strobe, b1.wr_strobe, b1.last_beat, b1.err, b1.addr, b1.data, b1.beat_count);
    end

    function automatic logic srdy();
        return sel ? b1.s_ready : b0.s_ready;
    endfunction

    function automatic logic sbusy();
        return sel ? b1.busy : b0.busy;
    endfunction

    task automatic go(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic idle_inputs();
        mv = 0; re = 0; we = 0; ra = 0; rdat = 0; mr = 0; be = 0; bl = '0;
    endtask

    task automatic noise();
        mv = 1'($urandom); re = 1'($urandom); we = 1'($urandom); be = 1'($urandom);
        bl = BW'($urandom); ra = 1'($urandom); rdat = 1'($urandom); mr = 1'($urandom);
    endtask

    // Schedules a whole transfer from the protocol rules and queues each expected strobe
    task automatic txn(input bit s, input bit wr, input logic [AW-1:0] a0, input bit ben,
                       input logic [BW-1:0] blen, input int dly, input logic [31:0] dv);
        int nb, h, sc, hc, t, gap;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        nb = ben ? ((blen == 0) ? 1 : int'(blen)) : 1;
        gap = s ? 0 : 4;
        a = a0;
        d = dv[7:0];
        sel = s;
        h = cyc;
        push(s, h + AW, a, d, 0, nb == 1, wr);
        for (int i = 0; i < AW; i++) begin
            go(h + i);
            noise();
            if (i == 0) begin
                mv = 1; re = !wr; we = wr; be = ben; bl = blen;
                cmp("s_ready_at_handshake", 32'(srdy()), 32'd1);
            end
            if (i == 1) cmp("busy_after_handshake", 32'(sbusy()), 32'd1);
            ra = a[i];
            if (i < DW) rdat = d[i];
        end
        sc = h + AW;
        for (int k = 1; k < nb; k++) begin
            go(sc);
            noise();
            if (wr) begin
                for (int c = sc + 1; c <= sc + dly; c++) begin
                    go(c);
                    noise();
                    mv = 0;
                end
                hc = sc + 1 + dly;
                a = a + 1'b1;
                d = (k < 4) ? dv[8*k +: 8] : DW'($urandom);
                push(s, hc + DW, a, d, k, k == nb - 1, 1'b1);
                for (int i = 0; i < DW; i++) begin
                    go(hc + i);
                    noise();
                    if (i == 0) begin
                        mv = 1;
                        cmp("s_ready_wait_hs", 32'(srdy()), 32'd1);
                    end
                    rdat = d[i];
                end
                sc = hc + DW;
            end else begin
                for (int c = sc + 1; c <= sc + dly; c++) begin
                    go(c);
                    noise();
                    mr = 0;
                end
                t = sc + 1 + dly;
                go(t);
                noise();
                mr = 1;
                a = a + 1'b1;
                push(s, t + gap + 1, a, '0, k, k == nb - 1, 1'b0);
                for (int c = t + 1; c <= t + gap; c++) begin
                    go(c);
                    noise();
                end
                sc = t + gap + 1;
            end
        end
        go(sc);
        noise();
        go(sc + 1);
        idle_inputs();
        cmp("s_ready_after_done", 32'(srdy()), 32'd1);
        cmp("busy_after_done", 32'(sbusy()), 32'd0);
    endtask

    task automatic bad(input bit s, input bit both);
        int h;
        sel = s;
        h = cyc;
        noise();
        mv = 1; re = both; we = both;
        eq[s].push_back(h + 1);
        go(h + 1);
        idle_inputs();
        cmp("s_ready_after_err", 32'(srdy()), 32'd1);
        cmp("busy_after_err", 32'(sbusy()), 32'd0);
    endtask

    task automatic check_idle0(input string tag);
        cmp({tag, "_addr"}, 32'(b0.addr), 32'd0);
        cmp({tag, "_data"}, 32'(b0.data), 32'd0);
        cmp({tag, "_beat_count"}, 32'(b0.beat_count), 32'd0);
        cmp({tag, "_strobes"}, 32'({b0.rd_strobe, b0.wr_strobe, b0.last_beat, b0.err}), 32'd0);
        cmp({tag, "_busy"}, 32'(b0.busy), 32'd0);
        cmp({tag, "_s_ready"}, 32'(b0.s_ready), 32'd1);
    endtask

    initial begin
        int h;
        sel = 0;
        idle_inputs();
        repeat (3) @(negedge clk);
        check_idle0("reset");
        cmp("reset_s_ready_dut1", 32'(b1.s_ready), 32'd1);
        reset = 0;
        @(negedge clk);
        txn(1'b0, 1'b1, 12'h5A3, 1'b0, 12'd0, 0, 32'h0000_00C6);
        txn(1'b0, 1'b1, 12'hFFE, 1'b1, 12'd3, 2, 32'h0033_2211);
        txn(1'b0, 1'b0, 12'h010, 1'b1, 12'd2, 5, 32'h0);
        txn(1'b1, 1'b0, 12'h010, 1'b1, 12'd2, 5, 32'h0);
        bad(1'b0, 1'b1);
        bad(1'b0, 1'b0);
        bad(1'b1, 1'b1);
        sel = 0;
        h = cyc;
        for (int i = 0; i <= 6; i++) begin
            go(h + i);
            noise();
            if (i == 0) begin mv = 1; re = 0; we = 1; end
            ra = 1; rdat = 1;
            if (i == 6) reset = 1;
        end
        go(h + 7);
        reset = 0;
        idle_inputs();
        check_idle0("mid_reset");
        txn(1'b0, 1'b1, 12'h0AB, 1'b0, 12'd0, 0, 32'h0000_005E);
        txn(1'b0, 1'b0, 12'h7FF, 1'b1, 12'd0, 0, 32'h0);
        txn(1'b1, 1'b0, 12'h7FF, 1'b1, 12'd0, 0, 32'h0);
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 9) == 0) bad(1'($urandom), 1'($urandom));
            else txn(1'($urandom), 1'($urandom), AW'($urandom), 1'($urandom),
                     BW'($urandom_range(0, 4)), int'($urandom_range(0, 3)), $urandom);
        end
        for (int i = 0; i < 50 && (q[0].size() + q[1].size() + eq[0].size() + eq[1].size()) > 0; i++) @(negedge clk);
        @(negedge clk);
        cmp("pending_expectations", 32'(q[0].size() + q[1].size() + eq[0].size() + eq[1].size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/serial_slave_rx.md
Name: serial_slave_rx

Overview:
Parametrised serial-bus slave receive port, the next generation of the fixed 12-bit-address / 8-bit-data slave input port. It deserialises the LSB-first address and write data from the master, then issues one-cycle read/write strobes towards the slave memory. It also supports single or burst transfers of configurable length, with auto-incrementing address and a paced read-burst gap. It sits between the bus interconnect master side and the slave register/memory block.

Parameters:
ADDR_W, 12, address width in bits; serial address phase length in cycles.
DATA_W, 8, write data width; must satisfy 1 <= DATA_W <= ADDR_W.
BLEN_W, 12, width of burst length and beat counter.
GAP_CYCLES, 4, idle cycles inserted between read-burst beats after m_ready (0 allowed).

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
m_valid  in  1  master request valid
read_enable  in  1  request is a read (sampled at handshake)
write_enable  in  1  request is a write (sampled at handshake)
rx_address  in  1  serial address bit, LSB first
rx_data  in  1  serial write data bit, LSB first
m_ready  in  1  master ready for next read-burst beat
burst_en  in  1  burst request (sampled at first handshake)
burst_len  in  BLEN_W  beats in burst; 0 treated as 1 (sampled at first handshake)
s_ready  out  1  slave can accept handshake
addr  out  ADDR_W  current beat address
data  out  DATA_W  current beat write data
rd_strobe  out  1  one-cycle read command
wr_strobe  out  1  one-cycle write command
beat_count  out  BLEN_W  index of current/last strobed beat
last_beat  out  1  high with the strobe of the final beat
busy  out  1  high whenever state != IDLE
err  out  1  one-cycle protocol-error pulse

Behaviour:
- Handshake = m_valid && s_ready. s_ready = 1 only in IDLE and WAIT_HS.
- Reset (sync, any state): state=IDLE; addr, data, beat_count = 0; strobes, last_beat, busy, err = 0; s_ready = 1. A transfer in progress is discarded with no strobe.
- States: IDLE, ADDR_RX, DATA_RX, STROBE, WAIT_HS, WAIT_RD, GAP.
- IDLE handshake:
  - Exactly one of read_enable/write_enable set: capture the mode, latch burst_en, and latch total beats = (burst_en ? max(burst_len,1) : 1).
  - Capture rx_address into addr[0] and rx_data into data[0]; beat_count = 0; go to ADDR_RX.
  - Both or neither enable set: err = 1 for one cycle, stay IDLE, no capture.
- ADDR_RX: bit i is captured on cycle i after the handshake (handshake cycle = bit 0).
  - Write: data bits captured in parallel for i < DATA_W; rx_data ignored for i >= DATA_W.
  - After bit ADDR_W-1 -> STROBE.
- STROBE (one cycle): rd_strobe or wr_strobe = 1; last_beat = 1 if beat_count == beats-1.
  - First-beat strobe occurs exactly ADDR_W cycles after the handshake.
  - Next state: last beat -> IDLE; write -> WAIT_HS; read -> WAIT_RD.
- WAIT_HS (write burst): s_ready = 1; read_enable/write_enable/burst inputs ignored.
  - On handshake: addr = addr+1 (mod 2^ADDR_W), beat_count += 1, capture data bit 0, go to DATA_RX.
- DATA_RX: captures data bits 1..DATA_W-1 -> STROBE. Strobe occurs DATA_W cycles after the handshake.
- WAIT_RD (read burst): no handshake needed.
  - When m_ready is sampled 1 on cycle t: addr += 1 (wrap), beat_count += 1, go to GAP.
  - GAP holds GAP_CYCLES cycles, then STROBE; strobe occurs at t+GAP_CYCLES+1. GAP_CYCLES=0 gives STROBE at t+1.
- addr/data hold their values between beats and after completion until the next capture.
- Address wrap from 2^ADDR_W-1 to 0 is legal; there is no error.
- m_valid during a non-ready state is ignored (no handshake).

Test Plan:
1. ADDR_W=12, DATA_W=8: single write, addr 0x5A3, data 0xC6 -> wr_strobe exactly 12 cycles after handshake, addr=0x5A3, data=0xC6, last_beat=1, s_ready back to 1 the next cycle.
2. Write burst, burst_len=3, base 0xFFE, data 0x11/0x22/0x33; later beats handshaked 2 cycles after WAIT_HS entry -> wr_strobes with addr 0xFFE/0xFFF/0x000, beat_count 0/1/2, last_beat on third only.
3. Read burst, burst_len=2, base 0x010, m_ready low 5 cycles then high at t -> second rd_strobe at t+5 (GAP_CYCLES=4) with addr=0x011; repeat with GAP_CYCLES=0 -> strobe at t+1.
4. Handshake with read_enable=write_enable=1, and again with both 0 -> err pulses one cycle each time, no strobes, busy stays 0, s_ready stays 1.
5. Reset asserted at address bit 6 of a write -> next cycle all outputs zero, s_ready=1; a following write to 0x0AB completes normally.
6. burst_en=1, burst_len=0, read addr 0x7FF -> exactly one rd_strobe with last_beat=1, then IDLE.
